booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Sequential signed 32x32 -> 64-bit multiplier implementing radix-2 Booth's algorithm, one Booth step per clock.
- Executes MIPS mult; sits between register A/B outputs and the high/low source muxes feeding the High/Low registers.
- Control unit drives Start and waits for the Done pulse before asserting RegHighW/RegLowW.
- Done is the multiplier's stop signal to the control unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH (Hi = upper WIDTH, Lo = lower WIDTH).

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request a multiply; sampled only in IDLE
- A  input  WIDTH  multiplicand, two's complement (from register A)
- B  input  WIDTH  multiplier, two's complement (from register B)
- Hi  output  WIDTH  upper half of last completed product
- Lo  output  WIDTH  lower half of last completed product
- Busy  output  1  high while an operation is in progress (CALC state)
- Done  output  1  one-cycle pulse: Hi/Lo just updated

Behaviour:
- Interface: one clock (Clk); Reset asynchronous, active-high. Reset forces state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, internal product register=0.
- States: IDLE, CALC, DONE.
- IDLE: Busy=0, Done=0. Start=1 at edge k: latch multiplicand M = sign-extend(A) to WIDTH+1 bits; load product register P (2*WIDTH+2 bits) = {(WIDTH+1) zeros, B, 1'b0}; counter=WIDTH; go to CALC. Start=0: stay.
- CALC: Busy=1. Each edge, on P[1:0]:
  - 01: upper WIDTH+1 bits += M.
  - 10: upper WIDTH+1 bits -= M.
  - 00/11: no add.
  - Then arithmetic shift right of whole P by 1. Counter decrements.
  - The WIDTH+1-bit accumulator makes A = -2^(WIDTH-1) exact; no overflow flag exists.
- On the step where the counter reaches 0 (edge k+WIDTH): Hi = P[2*WIDTH:WIDTH+1], Lo = P[WIDTH:1] (result of that final step); go to DONE.
- DONE: Done=1, Busy=0 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: Start sampled at edge k -> Done high during cycle after edge k+WIDTH (32 cycles for default). Next Start accepted at edge k+WIDTH+2 at earliest.
- Start during CALC or DONE: ignored, not queued. A/B changes after edge k have no effect (operands latched).
- Hi/Lo change only at completion; otherwise hold the previous product, including across ignored Starts.
- Reset mid-operation: immediate abort; Hi/Lo cleared to 0 (prior result lost), no Done pulse.
- Product is the exact signed 2*WIDTH-bit result for all operand pairs, including both operands = -2^(WIDTH-1).

Test Plan:
- Reset, A=3, B=5, Start pulse at edge k -> Busy=1 edges k..k+31; Done=1 exactly one cycle after edge k+32; Hi=0x00000000, Lo=0x0000000F.
- A=0xFFFFFFFF (-1), B=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF; A=-7, B=-6 -> Hi=0, Lo=0x0000002A.
- A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000. A=B=0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001. A=0x80000000, B=0x7FFFFFFF -> Hi=0xC0000000, Lo=0x80000000.
- Start held high continuously, and A/B changed mid-op -> first operation's product correct; exactly one Done per 34-cycle window; Hi/Lo stable between Done pulses.
- Complete 3*5, then start 100*100 and assert Reset at cycle 10 of CALC -> Hi=Lo=0, Busy=0, no Done; fresh Start afterwards gives Lo=0x00002710.
- Randomized 1000 signed pairs incl. 0, +/-1, extremes -> {Hi,Lo} equals signed 64-bit reference product; Done count equals Start-accepted count.

Source files
------------

// File: rtl/booth_multiplier_if.sv
// Operand/result bundle between the control unit and the Booth multiplier.
// The master side issues start with operands; the slave side returns Hi/Lo and status.
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output a,
        output b,
        input  hi,
        input  lo,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output hi,
        output lo,
        output busy,
        output done
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one Booth step per clock.
// Hi/Lo hold the last completed product; done pulses for one cycle when they update.
//
// state   | meaning
// IDLE    | waiting for start, operands latched on acceptance
// CALC    | one add/sub + arithmetic shift per cycle, WIDTH steps
// DONE    | one-cycle done pulse, then back to IDLE
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    booth_multiplier_if.slave   io_mul
);
    localparam int PW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_m;
    logic [PW-1:0]    r_p;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_acc_nxt;
    logic [PW-1:0]    w_p_shift;
    logic             w_last;
    logic             w_load;

    // Accumulator is WIDTH+1 bits so that subtracting the most negative
    // multiplicand cannot overflow.
    always_comb begin
        w_acc = r_p[PW-1:WIDTH+1];
        case (r_p[1:0])
            2'b01:   w_acc_nxt = w_acc + r_m;
            2'b10:   w_acc_nxt = w_acc - r_m;
            default: w_acc_nxt = w_acc;
        endcase
        w_p_shift = {w_acc_nxt[WIDTH], w_acc_nxt, r_p[WIDTH:1]};
    end

    assign w_last = (r_cnt == CW'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        io_mul.busy  = 1'b0;
        io_mul.done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_mul.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                io_mul.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                io_mul.done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_load) begin
            r_m   <= {io_mul.a[WIDTH-1], io_mul.a};
            r_p   <= {{(WIDTH + 1){1'b0}}, io_mul.b, 1'b0};
            r_cnt <= CW'(WIDTH);
        end else if (r_state == ST_CALC) begin
            r_p   <= w_p_shift;
            r_cnt <= r_cnt - CW'(1);
            // Results are taken from the final step directly, not from r_p.
            if (w_last) begin
                r_hi <= w_p_shift[2*WIDTH:WIDTH+1];
                r_lo <= w_p_shift[WIDTH:1];
            end
        end
    end

    assign io_mul.hi = r_hi;
    assign io_mul.lo = r_lo;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: expected products queued at start,
// popped and compared when done pulses.
`timescale 1ns/1ps
module tb_booth_multiplier;
    logic clk;
    logic rst;

    booth_multiplier_if #(.WIDTH(32)) io ();

    booth_multiplier #(.WIDTH(32)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_mul (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] q_exp[$];
    int          n_vec      = 0;
    int          n_err      = 0;
    int          n_started  = 0;
    int          n_done     = 0;
    int          n_unstable = 0;
    logic [63:0] prev_prod  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    always @(negedge clk) begin
        if (io.done) n_done++;
        if (!rst && !io.done && ({io.hi, io.lo} !== prev_prod)) n_unstable++;
        prev_prod = {io.hi, io.lo};
    end

    task automatic wait_done(output int lat, output int nbusy);
        bit seen;
        lat   = 0;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (io.done) seen = 1'b1;
            else if (io.busy) nbusy++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen && q_exp.size() > 0) begin
            chk("product", {io.hi, io.lo}, q_exp.pop_front());
            chk("busy_at_done", 64'(io.busy), 64'd0);
        end
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
        int lat;
        int nb;
        @(negedge clk);
        io.start = 1'b1;
        io.a     = a;
        io.b     = b;
        q_exp.push_back(ref_prod(a, b));
        n_started++;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        io.a     = $urandom;
        io.b     = $urandom;
        wait_done(lat, nb);
        chk("latency", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(nb), 64'd32);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int lat;
        int nb;
        rst      = 1'b1;
        io.start = 1'b0;
        io.a     = '0;
        io.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {io.hi, io.lo}, 64'd0);
        chk("reset_busy", 64'(io.busy), 64'd0);
        chk("reset_done", 64'(io.done), 64'd0);
        #2 rst = 1'b0;

        do_mul(32'd3, 32'd5);
        chk("3x5_lo", 64'(io.lo), 64'h0000_000F);
        do_mul(32'hFFFF_FFFF, 32'd1);
        do_mul(-32'sd7, -32'sd6);
        chk("m7xm6_lo", 64'(io.lo), 64'h0000_002A);
        do_mul(32'h8000_0000, 32'h8000_0000);
        chk("minxmin", {io.hi, io.lo}, 64'h4000_0000_0000_0000);
        do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        chk("maxxmax", {io.hi, io.lo}, 64'h3FFF_FFFF_0000_0001);
        do_mul(32'h8000_0000, 32'h7FFF_FFFF);
        chk("minxmax", {io.hi, io.lo}, 64'hC000_0000_8000_0000);

        // Start held high across two operations, operands changed mid-op.
        @(negedge clk);
        io.start = 1'b1;
        io.a     = 32'd3;
        io.b     = 32'd5;
        q_exp.push_back(ref_prod(32'd3, 32'd5));
        n_started++;
        @(posedge clk);
        #1;
        io.a = 32'hFFFF_FFF7;
        io.b = 32'd11;
        q_exp.push_back(ref_prod(32'hFFFF_FFF7, 32'd11));
        n_started++;
        wait_done(lat, nb);
        chk("held_lat1", 64'(lat), 64'd33);
        @(posedge clk);
        @(posedge clk);
        #1;
        io.a = $urandom;
        io.b = $urandom;
        wait_done(lat, nb);
        chk("held_lat2", 64'(lat), 64'd33);
        io.start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of an operation.
        do_mul(32'd3, 32'd5);
        @(negedge clk);
        io.start = 1'b1;
        io.a     = 32'd100;
        io.b     = 32'd100;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_prev", {io.hi, io.lo}, 64'd15);
        chk("busy_mid", 64'(io.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_hilo", {io.hi, io.lo}, 64'd0);
        chk("abort_busy", 64'(io.busy), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'(n_started));
        do_mul(32'd100, 32'd100);
        chk("100x100_lo", 64'(io.lo), 64'h0000_2710);

        for (int i = 0; i < 1000; i++) begin
            do_mul(pick_operand(), pick_operand());
        end

        repeat (5) @(negedge clk);
        chk("done_count", 64'(n_done), 64'(n_started));
        chk("hilo_stable", 64'(n_unstable), 64'd0);
        chk("queue_empty", 64'(q_exp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
